alu_seq: RTL and testbench

//  Parametrised successor of the VeriRISC accumulator ALU: WIDTH-bit datapath, extended op set,

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_mul_iter.sv | 48 ++++
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encoding (legacy VeriRISC codes 0-7 kept) and FSM states.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      HLT = 4'd0,
      SKZ = 4'd1,
      ADD = 4'd2,
      AND = 4'd3,
      XOR = 4'd4,
      LDA = 4'd5,
      STO = 4'd6,
      JMP = 4'd7,
      SUB = 4'd8,
      OR  = 4'd9,
      SHL = 4'd10,
      SHR = 4'd11,
      MUL = 4'd12
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] prod_o,
   output logic               done_o
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;

   // Product is exposed combinationally so the final partial product lands in the same edge as done.
   assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign prod_o = acc_d;
   assign done_o = busy_q && (cnt_q == CW'(WIDTH-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         mplier_q <= b_i;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready handshake, single-cycle op mux, optional iterative multiply,
// registered result and flags.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  alu_op_t          opcode,
   input  logic [WIDTH-1:0] accum,
   input  logic [WIDTH-1:0] data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             res_zero,
   output logic             res_carry,
   output logic             res_neg,
   output logic             zero
);

   alu_state_t         state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               carry_q, carry_d;
   logic               zero_q, neg_q;
   logic               accept, is_mul, mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_cy;
   logic [WIDTH:0]     add_w, sub_w;

   assign zero      = ~|accum;
   assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign is_mul    = MUL_EN && (opcode == MUL);
   assign out_valid = (state_q == DONE);
   assign out       = out_q;
   assign res_zero  = zero_q;
   assign res_carry = carry_q;
   assign res_neg   = neg_q;

   assign add_w = {1'b0, accum} + {1'b0, data};
   assign sub_w = {1'b0, accum} - {1'b0, data};

   // Unlisted codes (and MUL when the multiplier is absent) pass the accumulator through.
   always_comb begin
      alu_res = accum;
      alu_cy  = 1'b0;
      case (opcode)
         ADD: begin alu_res = add_w[WIDTH-1:0]; alu_cy = add_w[WIDTH]; end
         SUB: begin alu_res = sub_w[WIDTH-1:0]; alu_cy = sub_w[WIDTH]; end
         AND: alu_res = accum & data;
         OR:  alu_res = accum | data;
         XOR: alu_res = accum ^ data;
         LDA: alu_res = data;
         SHL: begin alu_res = {accum[WIDTH-2:0], 1'b0}; alu_cy = accum[WIDTH-1]; end
         SHR: begin alu_res = {1'b0, accum[WIDTH-1:1]}; alu_cy = accum[0]; end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      carry_d   = carry_q;
      mul_start = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               if (is_mul) begin
                  state_d   = BUSY;
                  mul_start = 1'b1;
               end else begin
                  state_d = DONE;
                  out_d   = alu_res;
                  carry_d = alu_cy;
               end
            end else if (state_q == DONE && out_ready) begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (mul_done) begin
               state_d = DONE;
               out_d   = mul_prod[WIDTH-1:0];
               carry_d = |mul_prod[2*WIDTH-1:WIDTH];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         carry_q <= carry_d;
         zero_q  <= ~|out_d;
         neg_q   <= out_d[WIDTH-1];
      end
   end

   generate
      if (MUL_EN) begin : g_mul
         mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst     (rst),
            .start_i (mul_start),
            .a_i     (accum),
            .b_i     (data),
            .prod_o  (mul_prod),
            .done_o  (mul_done)
         );
      end else begin : g_nomul
         assign mul_prod = '0;
         assign mul_done = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): one multiplier build, one pass-through build.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready, v0;
   alu_op_t    opcode;
   logic [7:0] accum, data;
   logic       in_ready, out_valid, res_zero, res_carry, res_neg, zero;
   logic [7:0] out;
   logic       in_ready0, out_valid0, res_zero0, res_carry0, res_neg0, zero0;
   logic [7:0] out0;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .accum(accum), .data(data), .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .res_zero(res_zero), .res_carry(res_carry), .res_neg(res_neg), .zero(zero)
   );

   alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(in_ready0), .opcode(opcode),
      .accum(accum), .data(data), .out_valid(out_valid0), .out_ready(1'b1), .out(out0),
      .res_zero(res_zero0), .res_carry(res_carry0), .res_neg(res_neg0), .zero(zero0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [7:0] e_out, input logic e_cy);
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_out"},   out,       e_out);
      chk({tag, "_carry"}, res_carry, e_cy);
      chk({tag, "_zero"},  res_zero,  e_out == 8'h00);
      chk({tag, "_neg"},   res_neg,   e_out[7]);
   endtask

   // Single-cycle op; operands are scrambled right after accept to prove they were captured.
   task automatic do_op(input string tag, input alu_op_t op, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] e_out, input logic e_cy);
      opcode = op; accum = a; data = d; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; accum = ~a; data = ~d;
      chk_res(tag, e_out, e_cy);
   endtask

   task automatic mul_op(input string tag, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] e_out, input logic e_cy);
      opcode = MUL; accum = a; data = d; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; accum = ~a; data = ~d;
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_busy_rdy"}, in_ready, 1'b0);
         chk({tag, "_busy_vld"}, out_valid, 1'b0);
         tick();
      end
      chk_res(tag, e_out, e_cy);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; v0 = 1'b0; out_ready = 1'b1;
      opcode = HLT; accum = 8'h00; data = 8'h00;
      tick(); tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", out, 8'h00);
      chk("rst_flags", {res_zero, res_carry, res_neg}, 3'b000);
      chk("zero_live_0", zero, 1'b1);
      rst = 1'b0; #1;
      chk("post_rst_ready", in_ready, 1'b1);
      accum = 8'h05; #1;
      chk("zero_live_5", zero, 1'b0);

      do_op("add",  ADD, 8'hF0, 8'h20, 8'h10, 1'b1);
      do_op("sub",  SUB, 8'h05, 8'h07, 8'hFE, 1'b1);
      do_op("sub0", SUB, 8'h07, 8'h07, 8'h00, 1'b0);
      do_op("and",  AND, 8'hF0, 8'h3C, 8'h30, 1'b0);
      do_op("or",   OR,  8'h0F, 8'h30, 8'h3F, 1'b0);
      do_op("xor",  XOR, 8'hFF, 8'h0F, 8'hF0, 1'b0);
      do_op("lda",  LDA, 8'h11, 8'h80, 8'h80, 1'b0);
      do_op("shl",  SHL, 8'h81, 8'h00, 8'h02, 1'b1);
      do_op("shr",  SHR, 8'h81, 8'h00, 8'h40, 1'b1);
      do_op("op15", alu_op_t'(4'hF), 8'h5A, 8'h33, 8'h5A, 1'b0);
      do_op("sto",  STO, 8'h00, 8'hFF, 8'h00, 1'b0);
      do_op("addw", ADD, 8'hFF, 8'h01, 8'h00, 1'b1);

      mul_op("mul",  8'h13, 8'h11, 8'h43, 1'b1);
      mul_op("mul2", 8'h0F, 8'h03, 8'h2D, 1'b0);
      mul_op("mulff", 8'hFF, 8'hFF, 8'h01, 1'b1);

      // Pass-through build: MUL completes in one cycle as accum.
      opcode = MUL; accum = 8'h13; data = 8'h11; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      chk("nomul_valid", out_valid0, 1'b1);
      chk("nomul_out", out0, 8'h13);
      chk("nomul_carry", res_carry0, 1'b0);

      // Backpressure: result held while consumer stalls, next op waits.
      tick();
      do_op("bp_add", ADD, 8'h01, 8'h02, 8'h03, 1'b0);
      out_ready = 1'b0;
      opcode = XOR; accum = 8'hF0; data = 8'h0F; in_valid = 1'b1; #1;
      chk("bp_rdy0", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_out", out, 8'h03);
         chk("bp_hold_vld", out_valid, 1'b1);
         chk("bp_hold_rdy", in_ready, 1'b0);
      end
      out_ready = 1'b1; #1;
      chk("bp_rdy1", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk_res("bp_xor", 8'hFF, 1'b0);

      // Reset during the 4th busy cycle of a multiply aborts it.
      tick();
      opcode = MUL; accum = 8'h13; data = 8'h11; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; accum = 8'h00; #1;
      chk("zero_busy", zero, 1'b1);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("abort_out", out, 8'h00);
      chk("abort_vld", out_valid, 1'b0);
      chk("abort_flags", {res_zero, res_carry, res_neg}, 3'b000);
      chk("abort_rdy_rst", in_ready, 1'b0);
      rst = 1'b0; #1;
      chk("abort_rdy", in_ready, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      chk("abort_no_vld", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
